// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the asynchronous FIFO read-side logic.
//   RD_BUF_DEPTH      : entries in the read-side output buffer
//   FRAME_CNT_W       : width of the frame word index
//   DEFAULT_FRAME_LEN : default number of words per frame
//   rd_ptr_inc()      : circular pointer increment for a 3-entry buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int RD_BUF_DEPTH      = 3;
    localparam int RD_PTR_W          = 2;
    localparam int FRAME_CNT_W       = 16;
    localparam int DEFAULT_FRAME_LEN = 8;

    // Pointers live in 0..2; the 2-bit encoding 3 is never reached.
    function automatic logic [RD_PTR_W-1:0] rd_ptr_inc(input logic [RD_PTR_W-1:0] ptr);
        return (ptr == RD_PTR_W'(RD_BUF_DEPTH - 1)) ? '0 : ptr + RD_PTR_W'(1);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// Three-entry circular buffer that holds words returned by the FIFO read port
// until the downstream stream accepts them.
// Ports:
//   clk_r      in   clock, rising edge
//   reset      in   synchronous active-high reset
//   push       in   write push_data at the tail this cycle
//   push_data  in   word to store
//   pop        in   advance the head this cycle
//   head_data  out  word at the head (meaningful when occ != 0)
//   occ        out  number of stored words, 0..3
// -----------------------------------------------------------------------------
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int width = 16
) (
    input  logic                clk_r,
    input  logic                reset,
    input  logic                push,
    input  logic [width-1:0]    push_data,
    input  logic                pop,
    output logic [width-1:0]    head_data,
    output logic [RD_PTR_W-1:0] occ
);

    logic [width-1:0]    mem_q [RD_BUF_DEPTH];
    logic [RD_PTR_W-1:0] head_q, head_d;
    logic [RD_PTR_W-1:0] tail_q, tail_d;
    logic [RD_PTR_W-1:0] occ_q, occ_d;
    logic                push_ok;
    logic                pop_ok;

    // The upstream credit check keeps push away from a full buffer; the guard
    // here only protects stored words should that contract ever be broken.
    assign pop_ok  = pop && (occ_q != '0);
    assign push_ok = push && ((occ_q != RD_PTR_W'(RD_BUF_DEPTH)) || pop_ok);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_ok) begin
            tail_d = rd_ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = rd_ptr_inc(head_q);
        end
        occ_d = occ_q + RD_PTR_W'(push_ok) - RD_PTR_W'(pop_ok);
    end

    always_ff @(posedge clk_r) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (push_ok) begin
                mem_q[tail_q] <= push_data;
            end
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drainer for the asynchronous FIFO. Issues reads against the FIFO
// read port, absorbs the one-cycle read latency in a 3-entry buffer and
// presents the words as a valid/ready stream with a frame marker every
// frame_len words. fifo_rd_en never depends on m_ready.
// Ports:
//   clk_r       in   read-domain clock, rising edge
//   reset       in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  FIFO read request, one word per high cycle
//   m_valid     out  downstream word valid
//   m_ready     in   downstream accept
//   m_data      out  downstream word (buffer head)
//   m_last      out  final word of the current frame
//   frame_cnt   out  index within the frame of the word at the head
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int width     = 16,
    parameter int frame_len = DEFAULT_FRAME_LEN
) (
    input  logic                   clk_r,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [width-1:0]       fifo_data,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [width-1:0]       m_data,
    output logic                   m_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [FRAME_CNT_W-1:0] LAST_IDX = FRAME_CNT_W'(frame_len - 1);

    logic                   inflight_q, inflight_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [RD_PTR_W-1:0]    occ;
    logic [width-1:0]       head_data;
    logic [RD_PTR_W:0]      credit_used;
    logic                   pop;

    rd_skid_buf #(
        .width (width)
    ) u_buf (
        .clk_r     (clk_r),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    // Words already buffered plus the one still coming back from the FIFO;
    // a new read is only allowed while a slot is guaranteed for its data.
    assign credit_used = {1'b0, occ} + {{RD_PTR_W{1'b0}}, inflight_q};
    assign fifo_rd_en  = !reset && !fifo_empty
                         && (credit_used < (RD_PTR_W+1)'(RD_BUF_DEPTH));

    // Outputs are forced quiet while reset is held so nothing stale leaks out
    // before the registers have been cleared.
    assign m_valid   = !reset && (occ != '0);
    assign m_data    = m_valid ? head_data : '0;
    assign m_last    = m_valid && (frame_cnt_q == LAST_IDX);
    assign frame_cnt = frame_cnt_q;
    assign pop       = m_valid && m_ready;

    always_comb begin
        inflight_d  = fifo_rd_en;
        frame_cnt_d = frame_cnt_q;
        if (pop) begin
            frame_cnt_d = (frame_cnt_q == LAST_IDX) ? '0 : frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_r) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream with a behavioural FIFO read port model
// and an in-order scoreboard of the words pushed into that model.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int W  = 16;
    localparam int FL = 8;

    logic          clk_r = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [15:0]   frame_cnt;

    fifo_rd_stream #(
        .width     (W),
        .frame_len (FL)
    ) dut (
        .clk_r      (clk_r),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_r = ~clk_r;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] sb[$];
    bit           gate_empty = 1'b0;
    int           outstanding = 0;
    int           xfer_idx = 0;
    int           n_xfer = 0;
    int           rd_pulses = 0;
    int           cyc_no = 0;
    logic         s_rd, s_v, s_last;
    logic [W-1:0] s_data;
    logic [15:0]  s_fc;
    logic [W-1:0] pend_data;
    bit           have_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One read-domain cycle: entered at a falling edge, drives the FIFO model,
    // samples outputs, scores any transfer, then advances to the next falling edge.
    task automatic cyc();
        logic [W-1:0] exp_w;
        fifo_empty = gate_empty || (fq.size() == 0);
        #1;
        s_rd   = fifo_rd_en;
        s_v    = m_valid;
        s_data = m_data;
        s_last = m_last;
        s_fc   = frame_cnt;
        chk("credit_bound", 32'(outstanding <= 3), 1);
        if (s_v && m_ready) begin
            chk("xfer_expected", 32'(sb.size() > 0), 1);
            exp_w = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("m_data", s_data, exp_w);
            chk("frame_cnt", s_fc, xfer_idx % FL);
            chk("m_last", s_last, 32'((xfer_idx % FL) == FL - 1));
            xfer_idx++;
            n_xfer++;
            outstanding--;
        end
        if (s_rd) begin
            rd_pulses++;
            outstanding++;
            pend_data = (fq.size() > 0) ? fq.pop_front() : 16'hBAD0;
            have_pend = 1'b1;
        end else begin
            have_pend = 1'b0;
        end
        @(negedge clk_r);
        fifo_data = have_pend ? pend_data : 16'hDEAD;
        cyc_no++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            cyc();
            chk("rst_rd_en", s_rd, 0);
            chk("rst_m_valid", s_v, 0);
        end
        reset       = 1'b0;
        sb          = fq;
        xfer_idx    = 0;
        outstanding = 0;
    endtask

    initial begin
        int base, rp0, first_c, last_c, n_last;
        logic [W-1:0] exp_next;

        reset      = 1'b1;
        m_ready    = 1'b0;
        fifo_data  = '0;
        fifo_empty = 1'b0;
        fq.push_back(16'hA5A5);
        @(negedge clk_r);

        // Reset held with a non-empty FIFO: everything quiet.
        repeat (3) begin
            cyc();
            chk("rst_rd_en", s_rd, 0);
            chk("rst_m_valid", s_v, 0);
            chk("rst_m_last", s_last, 0);
            chk("rst_m_data", s_data, 0);
            chk("rst_frame_cnt", s_fc, 0);
        end
        reset = 1'b0;
        sb = fq;
        xfer_idx = 0;
        outstanding = 0;

        // Single word: read in the first cycle out of reset, valid two later.
        m_ready = 1'b1;
        cyc();
        chk("single_rd_en_t0", s_rd, 1);
        chk("single_valid_t0", s_v, 0);
        cyc();
        chk("single_rd_en_t1", s_rd, 0);
        chk("single_valid_t1", s_v, 0);
        cyc();
        chk("single_valid_t2", s_v, 1);
        chk("single_data_t2", s_data, 16'hA5A5);
        chk("single_last_t2", s_last, 0);
        cyc();
        chk("single_valid_t3", s_v, 0);

        // Burst of 16 at full rate.
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            fq.push_back(W'(i));
            sb.push_back(W'(i));
        end
        m_ready = 1'b1;
        base = n_xfer; rp0 = rd_pulses; first_c = -1; last_c = 0; n_last = 0;
        for (int c = 0; c < 60 && (n_xfer - base) < 16; c++) begin
            cyc();
            if (s_v && m_ready) begin
                if (first_c < 0) first_c = cyc_no;
                last_c = cyc_no;
                if (s_last) n_last++;
            end
        end
        chk("burst_count", n_xfer - base, 16);
        chk("burst_span", last_c - first_c, 15);
        chk("burst_lasts", n_last, 2);
        chk("burst_reads", rd_pulses - rp0, 16);

        // Backpressure: only three reads, head word held.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            fq.push_back(W'(100 + i));
            sb.push_back(W'(100 + i));
        end
        m_ready = 1'b0;
        rp0 = rd_pulses;
        repeat (20) begin
            cyc();
            if (s_v) chk("bp_hold", s_data, 100);
        end
        chk("bp_reads", rd_pulses - rp0, 3);
        chk("bp_valid", s_v, 1);
        m_ready = 1'b1;
        base = n_xfer;
        for (int c = 0; c < 40 && sb.size() > 0; c++) cyc();
        chk("bp_drain", n_xfer - base, 10);

        // Mid-frame reset with words buffered.
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            fq.push_back(W'(200 + i));
            sb.push_back(W'(200 + i));
        end
        m_ready = 1'b1;
        base = n_xfer;
        for (int c = 0; c < 20 && (n_xfer - base) < 5; c++) cyc();
        chk("mid_pre_xfers", n_xfer - base, 5);
        m_ready = 1'b0;
        cyc();
        cyc();
        do_reset(2);
        exp_next = sb[0];
        m_ready = 1'b1;
        base = n_xfer;
        for (int c = 0; c < 10 && n_xfer == base; c++) cyc();
        chk("mid_post_seen", n_xfer - base, 1);
        chk("mid_post_fc", s_fc, 0);
        chk("mid_post_data", s_data, exp_next);
        for (int c = 0; c < 40 && sb.size() > 0; c++) cyc();
        chk("mid_drain_empty", sb.size(), 0);

        // Random ready and empty over 1000 words.
        do_reset(2);
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            fq.push_back(w);
            sb.push_back(w);
        end
        base = n_xfer;
        for (int c = 0; c < 10000 && (n_xfer - base) < 1000; c++) begin
            m_ready    = 1'($urandom_range(0, 1));
            gate_empty = ($urandom_range(0, 2) == 0);
            cyc();
        end
        gate_empty = 1'b0;
        chk("rand_count", n_xfer - base, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drainer for the asynchronous FIFO. It lives entirely in the read clock domain and pulls words through the FIFO read port (empty flag, read enable, read data). It presents those words downstream as a valid/ready stream, with a frame marker every `frame_len` words. It absorbs the FIFO's one-cycle read latency with a 3-entry output buffer, so it sustains one word per cycle without a combinational path from `m_ready` to `fifo_rd_en`.

## Interface
Parameters:
- `width`, 16, data word width; must match the FIFO `width`.
- `frame_len`, 8, words per frame; legal range 1..65535.

Ports:
- `clk_r`  in  1  read-domain clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  `width`  FIFO read data; valid in the cycle after `fifo_rd_en` was high.
- `fifo_rd_en`  out  1  FIFO read request; one word per high cycle.
- `m_valid`  out  1  downstream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `width`  downstream word.
- `m_last`  out  1  high with the final word of each frame.
- `frame_cnt`  out  16  index of the word currently at the head of the output, from 0 to `frame_len`-1.

## Operation
- State:
  - `occ`, buffer occupancy, 0..3.
  - `inflight`, 1 if `fifo_rd_en` was high in the previous cycle.
  - `frame_cnt`.
- Issue rule: `fifo_rd_en = !reset && !fifo_empty && (occ + inflight < 3)`.
  - `occ` and `inflight` are the registered values.
  - `fifo_rd_en` does not depend on `m_ready`.
- Capture: when `inflight` = 1, `fifo_data` is written to the buffer tail at the clock edge.
- Pop: a transfer occurs when `m_valid && m_ready`; the buffer head advances at the edge.
- Occupancy update: `occ_next = occ + inflight - pop`. Capture and pop in the same cycle leave `occ` unchanged.
- Output: `m_valid = (occ != 0)`. `m_data` is the buffer head; it holds stable while `m_valid && !m_ready`.
- Framing:
  - `m_last = m_valid && (frame_cnt == frame_len-1)`.
  - On each transfer, `frame_cnt` increments, and wraps to 0 after `frame_len-1`.
  - With `frame_len` = 1, `m_last` equals `m_valid`.
- The credit bound guarantees that no captured word is ever dropped: `occ + inflight` never exceeds 3.
- Buffer structure: circular, with 2-bit head and tail pointers that wrap 2→0.

## Timing
- Reset values:
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `frame_cnt` = 0.
  - `occ` = 0, `inflight` = 0, head and tail pointers = 0.
- Reset mid-operation: buffered and in-flight words are discarded. The data returned for a read issued in the cycle `reset` rises is ignored. The next accepted word is frame index 0.
- Latency: `fifo_rd_en` high in cycle t gives `m_valid` high in cycle t+2 when the buffer was empty.
- `fifo_empty` falling in cycle t gives `fifo_rd_en` high in the same cycle t, provided credit is available.
- Throughput: with `m_ready` held at 1 and `fifo_empty` held at 0, `fifo_rd_en` stays high continuously and one word transfers per cycle.
- Backpressure: with `m_ready` held at 0, at most 3 reads are issued; `fifo_rd_en` then stays low until a transfer occurs.
- `fifo_empty` high while a read is in flight does not cancel that read's capture.

## Structure
- Shared package `fifo_pkg`:
  - `RD_BUF_DEPTH` = 3.
  - `FRAME_CNT_W` = 16.
  - Default `frame_len`.
- Sub-module `rd_skid_buf`, parameterised by `width`:
  - 3-entry circular buffer with push/pop, head data and occupancy.
  - The top level keeps the credit, in-flight and frame-counter logic.

## Test plan
- Reset: hold `reset` for 3 cycles with `fifo_empty` = 0 -> all outputs are 0 during reset, and the first `fifo_rd_en` is in the first cycle after `reset` falls.
- Single word: `fifo_empty` low for 1 cycle, `fifo_data` = 16'hA5A5 on the next cycle, `m_ready` = 1 -> `m_valid` pulses for 1 cycle 2 cycles after `fifo_rd_en`, with `m_data` = 16'hA5A5 and `m_last` = 0.
- Burst: 16 words 0..15 queued, `m_ready` = 1 -> 16 consecutive transfers with data 0..15, and `m_last` high on words 7 and 15.
- Backpressure: 10 words queued and `m_ready` = 0 for 20 cycles -> exactly 3 `fifo_rd_en` pulses and `m_data` stable at word 0. After releasing `m_ready`, all 10 words arrive in order with none lost.
- Mid-frame reset: assert `reset` after 5 transfers with 2 words buffered -> buffered words are gone and the next transfer has `frame_cnt` = 0.
- Simultaneous capture and pop: random `m_ready` (50%) with random `fifo_empty` over 1000 words -> the output sequence equals the input sequence, `occ` + `inflight` never exceeds 3, and `m_last` is on every 8th word.
